// File: rtl/q_cycle_sequencer.sv
// Q-phase instruction-cycle controller: splits clk into Q1..Q4, drives fetch strobes,
// tracks flush/SLEEP/WAKE and counts retired instructions.
module q_cycle_sequencer #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sleep_req,
    input  logic                 wake,
    input  logic                 skip_req,
    input  logic                 jump_req,
    output logic [1:0]           phase,
    output logic                 pc_inc,
    output logic                 ir_load,
    output logic                 ex_valid,
    output logic                 asleep,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SLEEP = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q4 = 2'd3;

    state_t                 state_q, state_d;
    logic [1:0]             phase_q, phase_d;
    logic                   flush_q, flush_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic                   ex_valid_w;

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign ex_valid_w = (state_q == ST_RUN) && !flush_q;

    assign phase    = phase_q;
    assign pc_inc   = (phase_q == Q1) && ((state_q == ST_RUN) || (state_q == ST_WAKE));
    assign ir_load  = (phase_q == Q4) && (state_q != ST_SLEEP);
    assign ex_valid = ex_valid_w;
    assign asleep   = (state_q == ST_SLEEP);
    assign retired  = retired_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + 2'd1;
        flush_d   = flush_q;
        retired_d = retired_q;
        unique case (state_q)
            ST_FILL: begin
                if (phase_q == Q4) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (phase_q == Q4) begin
                    // A flushed cycle ignores its own requests, so the flag clears after one NOP.
                    flush_d = ex_valid_w && (skip_req || jump_req || sleep_req);
                    if (ex_valid_w) begin
                        retired_d = retired_q + CNT_WIDTH'(1);
                        if (sleep_req) begin
                            state_d = ST_SLEEP;
                            phase_d = Q1;
                        end
                    end
                end
            end
            ST_SLEEP: begin
                phase_d = Q1;
                if (wake) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (phase_q == Q4) begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_FILL;
                phase_d = Q1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FILL;
            phase_q   <= Q1;
            flush_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            flush_q   <= flush_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_q_cycle_sequencer.sv
// Scoreboard bench for q_cycle_sequencer: stimulus pushes hand-derived expected outputs
// per clock; a negedge monitor pops and compares.
module tb_q_cycle_sequencer;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sleep_req = 1'b0;
    logic          wake = 1'b0;
    logic          skip_req = 1'b0;
    logic          jump_req = 1'b0;
    logic [1:0]    phase;
    logic          pc_inc;
    logic          ir_load;
    logic          ex_valid;
    logic          asleep;
    logic [CW-1:0] retired;

    q_cycle_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sleep_req (sleep_req),
        .wake      (wake),
        .skip_req  (skip_req),
        .jump_req  (jump_req),
        .phase     (phase),
        .pc_inc    (pc_inc),
        .ir_load   (ir_load),
        .ex_valid  (ex_valid),
        .asleep    (asleep),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [1:0]    ph;
        logic          pci;
        logic          irl;
        logic          exv;
        logic          slp;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] exp_ret = '0;

    // Monitor: every clock presents a full output vector, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if ({phase, pc_inc, ir_load, ex_valid, asleep, retired} !==
                {e.ph, e.pci, e.irl, e.exv, e.slp, e.ret}) begin
                miscompares++;
                $display("FAIL %s @%0t: got ph=%0d pc_inc=%b ir_load=%b ex_valid=%b asleep=%b retired=%0d, want ph=%0d pc_inc=%b ir_load=%b ex_valid=%b asleep=%b retired=%0d",
                         e.tag, $time, phase, pc_inc, ir_load, ex_valid, asleep, retired,
                         e.ph, e.pci, e.irl, e.exv, e.slp, e.ret);
            end
        end
    end

    task automatic step(input logic r, input logic sl, input logic wk, input logic sk,
                        input logic jp, input logic [1:0] ph, input logic pci,
                        input logic irl, input logic exv, input logic slp, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; sleep_req = sl; wake = wk; skip_req = sk; jump_req = jp;
        e.tag = tag; e.ph = ph; e.pci = pci; e.irl = irl; e.exv = exv; e.slp = slp; e.ret = exp_ret;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int unsigned n, input string tag);
        exp_ret = '0;
        for (int i = 0; i < int'(n); i++) step(1'b1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, tag);
    endtask

    // Releases reset on the first record; the word at the reset PC is fetched without pc_inc.
    task automatic fill_cycle(input string tag);
        for (int p = 0; p < 4; p++)
            step(1'b0, 0, 0, 0, 0, 2'(p), 1'b0, (p == 3), 1'b0, 1'b0, tag);
    endtask

    task automatic run_cycle(input logic valid, input int unsigned last_ph, input int unsigned req_ph,
                             input logic sl, input logic sk, input logic jp, input logic wk,
                             input string tag);
        for (int p = 0; p <= int'(last_ph); p++) begin
            logic hit;
            hit = (p == int'(req_ph));
            step(1'b0, hit & sl, wk, hit & sk, hit & jp, 2'(p), (p == 0), (p == 3), valid, 1'b0, tag);
        end
        if (valid && last_ph == 3) exp_ret = exp_ret + 1'b1;
    endtask

    task automatic sleep_clks(input int unsigned n, input logic wk_last, input string tag);
        for (int i = 0; i < int'(n); i++)
            step(1'b0, 0, wk_last & (i == int'(n) - 1), 0, 0, 2'd0, 0, 0, 0, 1'b1, tag);
    endtask

    task automatic wake_cycle(input logic sl_q4, input string tag);
        for (int p = 0; p < 4; p++)
            step(1'b0, sl_q4 & (p == 3), 0, 0, 0, 2'(p), (p == 0), (p == 3), 1'b0, 1'b0, tag);
    endtask

    initial begin
        do_reset(2, "reset_hold");
        fill_cycle("fill");
        run_cycle(1, 3, 3, 0, 0, 0, 0, "run_first");

        run_cycle(1, 3, 3, 0, 0, 1, 0, "jump_q4");
        run_cycle(0, 3, 3, 0, 0, 1, 0, "jump_nop");        // jump in a flushed cycle is ignored
        run_cycle(1, 3, 3, 0, 0, 0, 0, "after_jump");
        run_cycle(1, 3, 3, 0, 1, 1, 0, "skip_jump_q4");
        run_cycle(0, 3, 3, 0, 0, 0, 0, "skip_jump_nop");
        run_cycle(1, 3, 3, 0, 0, 0, 0, "after_skip_jump");

        run_cycle(1, 3, 1, 0, 1, 0, 0, "skip_q2_only");
        run_cycle(1, 3, 3, 0, 0, 0, 1, "wake_in_run");     // wake outside SLEEP is ignored
        run_cycle(1, 3, 3, 0, 0, 0, 0, "after_skip_q2");

        run_cycle(1, 3, 3, 1, 0, 1, 0, "sleep_q4");
        sleep_clks(20, 1'b1, "asleep");
        wake_cycle(1'b1, "wake_refetch");
        run_cycle(1, 3, 3, 0, 0, 0, 0, "run_after_wake");

        run_cycle(1, 0, 3, 0, 0, 0, 0, "pre_reset_q1");
        do_reset(1, "reset_in_q2");
        do_reset(1, "reset_hold2");
        fill_cycle("fill2");
        run_cycle(1, 3, 3, 1, 0, 0, 0, "sleep_again");
        sleep_clks(5, 1'b0, "asleep2");
        do_reset(1, "reset_in_sleep");
        fill_cycle("fill3");

        for (int i = 0; i < 16; i++) run_cycle(1, 3, 3, 0, 0, 0, 0, "count16");
        run_cycle(1, 3, 3, 0, 0, 0, 0, "wrapped");

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
